nes_controller_port: RTL

NES_CONTROLLER_PORT -- requirements
Module: nes_controller_port

---
 rtl/nes_controller_port.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/nes_controller_port.sv
// NES controller port: pad scanner FSM, $4016 strobe and serial-read shift registers.
// Optional second controller on $4017 enabled by defining CONTROLLER2_EN.
module nes_controller_port #(
  parameter int SCAN_DIV = 600,
  parameter int SCAN_GAP = 200000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs_n,
  input  logic       addr,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       pad_latch,
  output logic       pad_clk,
  input  logic       pad1_data,
`ifdef CONTROLLER2_EN
  input  logic       pad2_data,
`endif
  output logic       scan_busy
);

  // state    | meaning
  // S_IDLE   | post-reset, start a scan next cycle
  // S_LATCH  | pad_latch high for SCAN_DIV cycles
  // S_SAMPLE | capture serial bit n from the pad(s)
  // S_CLK_HI | pad_clk high for SCAN_DIV cycles
  // S_CLK_LO | pad_clk low for SCAN_DIV cycles
  // S_COMMIT | publish inverted sample to btn registers
  // S_GAP    | idle SCAN_GAP cycles before the next scan
  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SAMPLE,
    S_CLK_HI,
    S_CLK_LO,
    S_COMMIT,
    S_GAP
  } state_t;

  localparam int DIV_LOAD_I = (SCAN_DIV > 0) ? SCAN_DIV - 1 : 0;
  localparam int GAP_LOAD_I = (SCAN_GAP > 0) ? SCAN_GAP - 1 : 0;
  localparam int CNT_MAX    = (GAP_LOAD_I > DIV_LOAD_I) ? GAP_LOAD_I : DIV_LOAD_I;
  localparam int CNT_W      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LOAD_I);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_LOAD_I);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       samp1_q;
  logic [7:0]       btn1_q;
  logic             pad_latch_q;
  logic             pad_clk_q;
  logic             busy_q;
`ifdef CONTROLLER2_EN
  logic [7:0]       samp2_q;
  logic [7:0]       btn2_q;
`endif

  // Scanner: timers are down-counters, each phase ends on terminal count zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      samp1_q     <= '0;
      btn1_q      <= 8'h00;
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CONTROLLER2_EN
      samp2_q     <= '0;
      btn2_q      <= 8'h00;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q     <= S_LATCH;
          cnt_q       <= DIV_LOAD;
          bit_q       <= '0;
          pad_latch_q <= 1'b1;
          pad_clk_q   <= 1'b0;
          busy_q      <= 1'b1;
        end
        S_LATCH: begin
          if (cnt_q == '0) begin
            state_q     <= S_SAMPLE;
            pad_latch_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_SAMPLE: begin
          samp1_q[bit_q] <= pad1_data;
`ifdef CONTROLLER2_EN
          samp2_q[bit_q] <= pad2_data;
`endif
          if (bit_q == 3'd7) begin
            state_q <= S_COMMIT;
          end else begin
            state_q   <= S_CLK_HI;
            cnt_q     <= DIV_LOAD;
            pad_clk_q <= 1'b1;
          end
        end
        S_CLK_HI: begin
          if (cnt_q == '0) begin
            state_q   <= S_CLK_LO;
            cnt_q     <= DIV_LOAD;
            pad_clk_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_CLK_LO: begin
          if (cnt_q == '0) begin
            state_q <= S_SAMPLE;
            bit_q   <= bit_q + 3'd1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_COMMIT: begin
          btn1_q  <= ~samp1_q;
`ifdef CONTROLLER2_EN
          btn2_q  <= ~samp2_q;
`endif
          state_q <= S_GAP;
          cnt_q   <= GAP_LOAD;
          busy_q  <= 1'b0;
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            state_q     <= S_LATCH;
            cnt_q       <= DIV_LOAD;
            bit_q       <= '0;
            pad_latch_q <= 1'b1;
            busy_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cnt_q       <= '0;
          pad_latch_q <= 1'b0;
          pad_clk_q   <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign pad_latch = pad_latch_q;
  assign pad_clk   = pad_clk_q;
  assign scan_busy = busy_q;

  // CPU side
  logic       strobe_q, strobe_d;
  logic       rd_prev_q;
  logic [7:0] shift1_q, shift1_d;
  logic       rd_act, rd_edge, wr_any, wr_hit;
  logic       unused_din;

  assign unused_din = ^din[7:1];
  assign rd_act     = !cs_n && rd;
  assign rd_edge    = rd_act && !rd_prev_q;
  assign wr_any     = !cs_n && wr;
  assign wr_hit     = wr_any && !addr;

`ifdef CONTROLLER2_EN
  logic [7:0] shift2_q, shift2_d;
`endif

  // A write in the same cycle as a read wins and suppresses the shift.
  always_comb begin
    strobe_d = strobe_q;
    shift1_d = shift1_q;
`ifdef CONTROLLER2_EN
    shift2_d = shift2_q;
`endif
    if (wr_hit) strobe_d = din[0];
    if (strobe_q) begin
      shift1_d = btn1_q;
`ifdef CONTROLLER2_EN
      shift2_d = btn2_q;
`endif
    end else if (rd_edge && !wr_any) begin
      if (!addr) shift1_d = {1'b1, shift1_q[7:1]};
`ifdef CONTROLLER2_EN
      else       shift2_d = {1'b1, shift2_q[7:1]};
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q  <= 1'b0;
      rd_prev_q <= 1'b0;
      shift1_q  <= 8'hFF;
`ifdef CONTROLLER2_EN
      shift2_q  <= 8'hFF;
`endif
    end else begin
      strobe_q  <= strobe_d;
      rd_prev_q <= rd_act;
      shift1_q  <= shift1_d;
`ifdef CONTROLLER2_EN
      shift2_q  <= shift2_d;
`endif
    end
  end

  always_comb begin
    dout = 8'h00;
    if (rd_act) begin
      if (!addr) begin
        dout = 8'h40 | {7'b0, (strobe_q ? btn1_q[0] : shift1_q[0])};
      end else begin
`ifdef CONTROLLER2_EN
        dout = 8'h40 | {7'b0, (strobe_q ? btn2_q[0] : shift2_q[0])};
`else
        dout = 8'h40;
`endif
      end
    end
  end

endmodule
